// File: rtl/ring_phase_monitor.sv
// Checks a one-hot ring counter for legal single-step rotation, decodes the hot-bit phase and counts revolutions.
// Latency: one cycle from a Ring sample to every output; all outputs are registered.
// Backpressure: none; Ring is sampled unconditionally on every rising edge.
module ring_phase_monitor #(
    parameter int WIDTH    = 4,
    parameter int PW       = $clog2(WIDTH),
    parameter int REV_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic             Clock,
    input  logic             ORI,
    input  logic [WIDTH-1:0] Ring,
    input  logic             Clear,
    output logic [PW-1:0]    Phase,
    output logic             PhaseValid,
    output logic             Locked,
    output logic             Error,
    output logic [REV_W-1:0] RevCount,
    output logic             RevPulse
);

    localparam int CW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ring_q;
    logic [CW-1:0]    good_cnt, good_cnt_nxt;
    logic             err_nxt;
    logic [REV_W-1:0] rev_nxt;
    logic             pulse_nxt;

    logic             onehot;
    logic             step_ok;
    logic             wrap;
    logic [PW-1:0]    hot_idx;
    logic [WIDTH-1:0] ring_rot;

    assign ring_rot = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
    // Clearing the lowest set bit leaves zero only for a single-bit value.
    assign onehot   = (Ring != '0) && ((Ring & (Ring - WIDTH'(1))) == '0);
    assign step_ok  = onehot && (Ring == ring_rot);
    assign wrap     = step_ok && Ring[0];

    always_comb begin
        hot_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (Ring[i]) begin
                hot_idx = PW'(i);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        err_nxt      = Error;
        rev_nxt      = RevCount;
        pulse_nxt    = 1'b0;
        case (state)
            SYNC: begin
                if (step_ok) begin
                    if (good_cnt == CW'(LOCK_CNT - 1)) begin
                        state_nxt    = LOCKED;
                        good_cnt_nxt = '0;
                    end else begin
                        good_cnt_nxt = good_cnt + CW'(1);
                    end
                end else begin
                    good_cnt_nxt = '0;
                end
            end
            LOCKED: begin
                if (!step_ok) begin
                    state_nxt = FAULT;
                    err_nxt   = 1'b1;
                end else if (wrap) begin
                    rev_nxt   = RevCount + REV_W'(1);
                    pulse_nxt = 1'b1;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt    = SYNC;
                good_cnt_nxt = '0;
            end
        endcase
        // Clear outranks every decision above, including a fault on the same edge.
        if (Clear) begin
            state_nxt    = SYNC;
            good_cnt_nxt = '0;
            err_nxt      = 1'b0;
            rev_nxt      = '0;
            pulse_nxt    = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge ORI) begin
        if (!ORI) begin
            state      <= SYNC;
            ring_q     <= '0;
            good_cnt   <= '0;
            Phase      <= '0;
            PhaseValid <= 1'b0;
            Locked     <= 1'b0;
            Error      <= 1'b0;
            RevCount   <= '0;
            RevPulse   <= 1'b0;
        end else begin
            state      <= state_nxt;
            ring_q     <= Ring;
            good_cnt   <= good_cnt_nxt;
            PhaseValid <= onehot;
            if (onehot) begin
                Phase <= hot_idx;
            end
            Locked     <= (state_nxt == LOCKED);
            Error      <= err_nxt;
            RevCount   <= rev_nxt;
            RevPulse   <= pulse_nxt;
        end
    end

endmodule

// File: doc/ring_phase_monitor.md
# ring_phase_monitor

Checker and decoder that sits directly downstream of the 4-bit one-hot ring counter. It samples the ring state every clock and verifies that it stays one-hot and advances one position per cycle (bit i moves to bit i+1, MSB back to bit 0). It encodes the hot-bit position as a binary phase index and counts full revolutions. Status outputs (lock, sticky error) let the system detect a corrupted ring, e.g. after a glitch or a missed preset.

## Interface
- WIDTH, 4: ring width in bits; legal values are 2 or more.
- PW, $clog2(WIDTH): width of the phase index.
- REV_W, 8: width of the revolution counter.
- LOCK_CNT, 2: consecutive correct steps required to reach the LOCKED state; legal values are 1 or more.
- Clock  in  1  single clock; all state updates on the rising edge.
- ORI  in  1  reset; asynchronous, active-low.
- Ring  in  WIDTH  ring counter state, sampled on every rising edge.
- Clear  in  1  synchronous clear of error, lock and revolution state.
- Phase  out  PW  index of the hot bit in the last sampled Ring.
- PhaseValid  out  1  last sampled Ring was exactly one-hot.
- Locked  out  1  high while the FSM is in LOCKED.
- Error  out  1  sticky fault flag.
- RevCount  out  REV_W  completed revolutions while LOCKED, modulo 2^REV_W.
- RevPulse  out  1  one-cycle strobe for each counted revolution.

## Operation
- Internal state:
  - Ring_q: the previous sample of Ring.
  - good_cnt: counts consecutive correct steps.
  - FSM with states SYNC, LOCKED and FAULT.
- Per-edge terms:
  - onehot: Ring has exactly one bit set.
  - step_ok: onehot AND Ring == rotate_left_by_1(Ring_q), where Ring_q[WIDTH-1] wraps to bit 0.
  - wrap: step_ok AND Ring[0].
- Ring_q <= Ring on every edge, including edges where Clear is high.
- Phase and PhaseValid:
  - If onehot: Phase <= index of the set bit; PhaseValid <= 1.
  - Otherwise: Phase holds its value; PhaseValid <= 0.
  - This runs in all FSM states.
- SYNC:
  - step_ok with good_cnt == LOCK_CNT-1: go to LOCKED and clear good_cnt.
  - step_ok otherwise: good_cnt increments.
  - Not step_ok: good_cnt <= 0.
  - Error is never set from this state.
- LOCKED:
  - step_ok: stay in LOCKED.
  - wrap: RevCount increments (wrapping at 2^REV_W) and RevPulse <= 1.
  - Not step_ok: go to FAULT and set Error <= 1.
- FAULT:
  - Holds until Clear.
  - RevCount frozen; RevPulse stays 0.
- Clear (when ORI is high):
  - Overrides every FSM decision on that edge.
  - Forces state to SYNC; clears good_cnt, Error, RevCount and RevPulse.
- RevPulse is 0 on every edge where it is not set by the LOCKED wrap rule.
- Locked is a registered decode of state == LOCKED.

## Timing
- ORI low:
  - Immediately, without a clock, forces: state SYNC, Ring_q 0, good_cnt 0, Phase 0, PhaseValid 0, Locked 0, Error 0, RevCount 0, RevPulse 0.
  - This applies at any time, including mid-revolution or in FAULT.
- All outputs are registered. A Ring value present before edge N is reflected in outputs after edge N (latency 1).
- Startup with ORI shared with the ring counter (ring preset to 0001):
  - E1 (first edge after release) samples 0001. Ring_q was 0, so the step fails and good_cnt stays 0.
  - E2 samples 0010: good_cnt = 1.
  - E3 samples 0100: Locked = 1 after E3.
  - E4 samples 1000.
  - E5 samples 0001: RevPulse = 1 and RevCount = 1 after E5.
  - Thereafter RevPulse repeats every WIDTH edges.
- Error asserts on the same edge the bad sample is taken. Locked falls on that edge.
- Clear and a bad sample on the same edge: Clear wins and Error stays 0.
- Clear while LOCKED: drops to SYNC. With a clean ring, Locked returns LOCK_CNT edges later.
- A one-hot sample that skips a position (e.g. 0010 then 1000) is a fault, although PhaseValid = 1.
- An all-zero or multi-hot sample is a fault and sets PhaseValid = 0.

## Test plan
- **Startup:** release ORI, drive an ideal 4-bit ring from 0001.
  - Locked = 1 after E3.
  - RevPulse after E5 and after E9.
  - RevCount = 2 after E9.
  - Phase sequence 0,1,2,3,0.
- **Multi-hot fault:** while LOCKED, inject Ring = 0011 for one cycle.
  - After that edge: Error = 1, Locked = 0, PhaseValid = 0.
  - Error stays 1 and RevCount stays frozen while clean rotation resumes.
- **Skip fault:** while LOCKED, drive 0010 then 1000.
  - Error = 1 and PhaseValid = 1 with Phase = 3.
- **Clear recovery:** from FAULT, pulse Clear for one cycle.
  - Error = 0, RevCount = 0.
  - Locked returns after exactly LOCK_CNT good steps.
  - Repeat with Clear coinciding with a bad sample: Error stays 0.
- **Counter wrap:** with REV_W = 2, run 5 revolutions.
  - RevCount goes 1, 2, 3, 0, 1.
  - RevPulse fires every revolution.
- **Async reset:** drive ORI low between clock edges mid-revolution.
  - All outputs reach their reset values before the next edge.
  - After release, the startup sequence repeats exactly.
